// File: rtl/histo_pkg.sv
// Shared definitions for the histogram readout sequencer: FSM encoding and header layout.
package histo_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_PUSH = 3'd4;
    localparam logic [2:0] ST_TRL  = 3'd5;

    typedef logic [2:0] state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Header word, MSB first: sync byte, 4-bit channel, sequence number filling the rest.
    localparam int SYNC_W      = 8;
    localparam int CH_FIELD_W  = 4;
    localparam int HDR_FIXED_W = SYNC_W + CH_FIELD_W;

endpackage

// File: rtl/histo_ch_arbiter.sv
// Per-channel histo_done edge detect, pending/overrun bookkeeping and
// lowest-index-first channel selection.
module histo_ch_arbiter
    import histo_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] histo_done,
    input  logic              take,
    input  logic              active,
    input  logic [CH_W-1:0]   act_ch,
    input  logic              overrun_clr,
    output logic              pending_any,
    output logic [CH_W-1:0]   next_ch,
    output logic [NUM_CH-1:0] overrun
);

    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] busy_mask;
    logic [NUM_CH-1:0] take_mask;
    logic [NUM_CH-1:0] ovr_set;

    always_comb begin
        rise      = histo_done & ~done_q;
        busy_mask = '0;
        if (active) busy_mask[act_ch] = 1'b1;
        take_mask = '0;
        if (take) take_mask[next_ch] = 1'b1;
        // A second completion before the first was read out is dropped, only flagged.
        ovr_set   = rise & (pending | busy_mask);
        next_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) next_ch = CH_W'(i);
        end
    end

    assign pending_any = |pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            done_q  <= histo_done;
            pending <= (pending & ~take_mask) | (rise & ~ovr_set);
            overrun <= (overrun & ~{NUM_CH{overrun_clr}}) | ovr_set;
        end
    end

endmodule

// File: rtl/histo_readout_seq.sv
// Sweeps a finished channel's histogram RAM and frames it as header, bin
// counts and checksum trailer on a valid/ready stream.
//
// state | meaning
// IDLE  | no packet in flight, waiting for a pending channel
// HDR   | presenting the header word
// RD    | one-cycle read strobe for the current bin
// WAIT  | counting down RAM read latency, captures rd_data on terminal count
// PUSH  | presenting the captured bin count
// TRL   | presenting the checksum trailer with out_last
module histo_readout_seq
    import histo_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          NUM_BINS  = 1024,
    parameter int          DATA_W    = 24,
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         BIN_W     = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] histo_done,
    output logic              rd_en,
    output logic [CH_W-1:0]   rd_ch,
    output logic [BIN_W-1:0]  rd_bin,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [NUM_CH-1:0] clear_req,
    output logic [NUM_CH-1:0] overrun,
    input  logic              overrun_clr,
    output logic              busy
);

    localparam int         SEQ_W    = DATA_W - HDR_FIXED_W;
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t                  state;
    logic [CH_W-1:0]         act_ch;
    logic [BIN_W-1:0]        bin;
    logic [1:0]              lat_cnt;
    logic [DATA_W-1:0]       word;
    logic [DATA_W-1:0]       csum;
    logic [SEQ_W-1:0]        seq;
    logic                    pending_any;
    logic [CH_W-1:0]         next_ch;
    logic                    take;
    logic [CH_FIELD_W-1:0]   ch_field;

    assign take = (state == ST_IDLE) && pending_any;
    assign busy = (state != ST_IDLE);

    histo_ch_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .histo_done  (histo_done),
        .take        (take),
        .active      (busy),
        .act_ch      (act_ch),
        .overrun_clr (overrun_clr),
        .pending_any (pending_any),
        .next_ch     (next_ch),
        .overrun     (overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            act_ch    <= '0;
            bin       <= '0;
            lat_cnt   <= '0;
            word      <= '0;
            csum      <= '0;
            seq       <= '0;
            clear_req <= '0;
        end else begin
            clear_req <= '0;
            case (state)
                ST_IDLE: if (pending_any) begin
                    act_ch <= next_ch;
                    state  <= ST_HDR;
                end
                ST_HDR: if (out_ready) begin
                    bin   <= '0;
                    csum  <= '0;
                    state <= ST_RD;
                end
                ST_RD: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        word  <= rd_data;
                        state <= ST_PUSH;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_PUSH: if (out_ready) begin
                    csum <= csum + word;
                    if (bin == BIN_W'(NUM_BINS - 1)) begin
                        state <= ST_TRL;
                    end else begin
                        bin   <= bin + 1'b1;
                        state <= ST_RD;
                    end
                end
                ST_TRL: if (out_ready) begin
                    clear_req[act_ch] <= 1'b1;
                    seq               <= seq + 1'b1;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_field              = '0;
        ch_field[CH_W-1:0]    = act_ch;
    end

    // Output word comes only from registers, so it cannot move while stalled.
    always_comb begin
        out_data = '0;
        case (state)
            ST_HDR:  out_data = {SYNC_BYTE, ch_field, seq};
            ST_PUSH: out_data = word;
            ST_TRL:  out_data = csum;
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state == ST_HDR) || (state == ST_PUSH) || (state == ST_TRL);
    assign out_last  = (state == ST_TRL);
    assign rd_en     = (state == ST_RD);
    assign rd_ch     = act_ch;
    assign rd_bin    = bin;

endmodule
